spi_iram_loader: RTL
====================

Name: spi_iram_loader

Overview:
- SPI-slave (mode 0, MSB first) program loader that writes CPU instruction RAM through a normal write port, replacing hierarchical preloading of `iram`.
- Sits in `top` between the `nCS`/`SCK`/`MOSI` pins and the `cpu_top` instruction-RAM write port.
- Holds the CPU in reset while a program is loaded, then releases it on a RUN command.
- Parametrised in word width, address width, synchroniser depth and hold-at-reset mode.

Parameters:
- DATA_W, 16: instruction/data word width in bits; also the SPI frame word size.
- ADDR_W, 10: instruction RAM address width.
- SYNC_STAGES, 2: flip-flop stages in each pin synchroniser; minimum 2.
- HOLD_ON_RESET, 1: cpu_hold value after reset. 1 means the CPU is held until RUN; 0 means the CPU runs immediately.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- nCS  in  1  SPI chip select, active low, asynchronous to clk.
- SCK  in  1  SPI clock, asynchronous to clk, idle low.
- MOSI  in  1  SPI data, sampled on SCK rising edge.
- mem_we  out  1  one-cycle write strobe to instruction RAM.
- mem_addr  out  ADDR_W  write address.
- mem_wdata  out  DATA_W  write data.
- cpu_hold  out  1  CPU reset request, active high.
- busy  out  1  high while nCS is (synchronised) low and a frame is in progress.
- frame_err  out  1  sticky flag: a frame ended mid-word; cleared at the next frame start.

Behaviour:
- Reset values: mem_we=0, mem_addr=0, mem_wdata=0, busy=0, frame_err=0, cpu_hold=HOLD_ON_RESET, state=IDLE, shift register=0, bit counter=0.
- Synchronisation:
  - nCS, SCK and MOSI each pass through SYNC_STAGES flops.
  - A rising edge of SCK is detected from the last synchronised stage and its previous value.
  - MOSI is sampled on the same clk cycle the edge is detected.
  - Requires f_clk >= 4 x f_SCK.
- Bit counter: counts 0..DATA_W-1 and wraps to 0 after each full word.
- Word assembly: shift register shifts left, inserting MOSI at the LSB. A word is complete on the DATA_W-th detected SCK rise.
- States:
  - IDLE: wait for synchronised nCS to fall; on the fall, clear frame_err, set busy, go to HDR.
  - HDR: on word complete, decode the header's top 2 bits:
    - 2'b10 (WRITE): mem_addr <= header[ADDR_W-1:0]; go to DATA.
    - 2'b11 (RUN): cpu_hold <= 0; go to DISCARD.
    - 2'b01 (HOLD): cpu_hold <= 1; go to DISCARD.
    - 2'b00 (NOP): go to DISCARD.
  - DATA: on word complete, mem_wdata <= word and mem_we=1 for exactly one clk cycle, on the cycle after the edge that completes the word. mem_addr increments by 1 on the cycle after the mem_we pulse.
  - DISCARD: ignore further bits until nCS rises.
- Frame end:
  - Synchronised nCS rise in any non-IDLE state returns to IDLE, clears busy and the bit counter, and never writes a partial word.
  - If the bit counter is nonzero at that point, set frame_err.
- Address wrap: increment from 2^ADDR_W-1 wraps to 0, with no error.
- Simultaneous events: if nCS rises on the same cycle as a completing SCK edge, the edge is processed first, so the word is written (or the header decoded), then the block returns to IDLE.
- SCK edges while synchronised nCS is high are ignored.
- Reset mid-operation (reset low at any time): all outputs return to reset values immediately; any in-flight word is lost.
- cpu_hold changes only on a RUN or HOLD header (or on reset); it is not altered by frame boundaries.

Test Plan:
- Reset with HOLD_ON_RESET=1 -> cpu_hold=1, mem_we=0, busy=0; after reset release, cpu_hold stays 1 with no SPI activity.
- Frame with header 16'h8000 followed by words 16'h8003, 16'h8101, 16'h0dc0 -> three mem_we pulses, at addresses 0, 1, 2 with data 8003, 8101, 0dc0 respectively; busy is high for the frame duration; frame_err=0.
- Frame with header 16'h83FF followed by 2 words, with ADDR_W=10 -> writes land at 0x3FF and then 0x000 (wrap).
- Frame with header 16'h8010, then 7 bits, then nCS raised -> no mem_we; frame_err=1. The next frame start clears frame_err.
- Frame with header 16'hC000 -> cpu_hold falls after the header word; following frame with header 16'h4000 -> cpu_hold=1 again; mem_we never asserted.
- reset asserted mid-DATA word (after 9 bits), then released, then a clean WRITE frame -> no spurious write; the clean frame writes at its header address with correct data.

Source files
------------

// File: rtl/spi_iram_loader.sv
// spi_iram_loader
//   SPI slave (mode 0, MSB first) that loads CPU instruction RAM through its
//   normal write port and controls the CPU reset request.
//   Frame = header word, then (for WRITE) any number of data words.
//   Header top bits: 10 WRITE (low ADDR_W bits = start address), 11 RUN,
//   01 HOLD, 00 NOP.
// Ports:
//   clk, reset      system clock, asynchronous active-low reset
//   nCS, SCK, MOSI  SPI pins, asynchronous to clk (f_clk >= 4 x f_SCK)
//   mem_we          one-cycle instruction RAM write strobe
//   mem_addr        write address (post-increments after each write)
//   mem_wdata       write data
//   cpu_hold        CPU reset request, active high
//   busy            frame in progress
//   frame_err       sticky: last frame ended mid-word
module spi_iram_loader #(
    parameter int unsigned DATA_W        = 16,
    parameter int unsigned ADDR_W        = 10,
    parameter int unsigned SYNC_STAGES   = 2,
    parameter bit          HOLD_ON_RESET = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              nCS,
    input  logic              SCK,
    input  logic              MOSI,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              cpu_hold,
    output logic              busy,
    output logic              frame_err
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    typedef enum logic [1:0] {IDLE, HDR, DATA, DISCARD} state_e;

    state_e                 state_q, state_d;
    logic [SYNC_STAGES-1:0] ncs_sync_q, ncs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   ncs_prev_q, ncs_prev_d;
    logic                   sck_prev_q, sck_prev_d;
    // Only DATA_W-1 bits need storing; the newest bit comes straight from MOSI.
    logic [DATA_W-2:0]      shift_q, shift_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic                   mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]      mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]      mem_wdata_q, mem_wdata_d;
    logic                   cpu_hold_q, cpu_hold_d;
    logic                   busy_q, busy_d;
    logic                   frame_err_q, frame_err_d;

    logic                   ncs_s, sck_s, mosi_s;
    logic                   ncs_fall, ncs_rise, sck_rise, word_done;
    logic [DATA_W-1:0]      word;

    assign ncs_s  = ncs_sync_q[SYNC_STAGES-1];
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign ncs_fall = ~ncs_s & ncs_prev_q;
    assign ncs_rise = ncs_s & ~ncs_prev_q;
    // Gated on the previous nCS sample so an edge arriving together with the
    // nCS rise is still processed before the frame closes.
    assign sck_rise  = sck_s & ~sck_prev_q & ~ncs_prev_q;
    assign word      = {shift_q, mosi_s};
    assign word_done = sck_rise && (bit_cnt_q == CNT_W'(DATA_W - 1));

    always_comb begin
        state_d     = state_q;
        ncs_sync_d  = {ncs_sync_q[SYNC_STAGES-2:0], nCS};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        ncs_prev_d  = ncs_s;
        sck_prev_d  = sck_s;
        shift_d     = shift_q;
        bit_cnt_d   = bit_cnt_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        cpu_hold_d  = cpu_hold_q;
        busy_d      = busy_q;
        frame_err_d = frame_err_q;

        if (mem_we_q) begin
            mem_addr_d = mem_addr_q + ADDR_W'(1);
        end

        if (sck_rise && state_q != IDLE) begin
            shift_d   = word[DATA_W-2:0];
            bit_cnt_d = word_done ? '0 : bit_cnt_q + CNT_W'(1);
        end

        unique case (state_q)
            IDLE: begin
                if (ncs_fall) begin
                    frame_err_d = 1'b0;
                    busy_d      = 1'b1;
                    state_d     = HDR;
                end
            end
            HDR: begin
                if (word_done) begin
                    unique case (word[DATA_W-1 -: 2])
                        2'b10: begin
                            mem_addr_d = word[ADDR_W-1:0];
                            state_d    = DATA;
                        end
                        2'b11: begin
                            cpu_hold_d = 1'b0;
                            state_d    = DISCARD;
                        end
                        2'b01: begin
                            cpu_hold_d = 1'b1;
                            state_d    = DISCARD;
                        end
                        default: state_d = DISCARD;
                    endcase
                end
            end
            DATA: begin
                if (word_done) begin
                    mem_wdata_d = word;
                    mem_we_d    = 1'b1;
                end
            end
            default: ;
        endcase

        // Frame close is applied after any same-cycle edge, so the counter
        // value checked here already includes that final bit.
        if (ncs_rise && state_q != IDLE) begin
            if (bit_cnt_d != '0) begin
                frame_err_d = 1'b1;
            end
            bit_cnt_d = '0;
            busy_d    = 1'b0;
            state_d   = IDLE;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            ncs_sync_q  <= '1;
            sck_sync_q  <= '0;
            mosi_sync_q <= '0;
            ncs_prev_q  <= 1'b1;
            sck_prev_q  <= 1'b0;
            shift_q     <= '0;
            bit_cnt_q   <= '0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            cpu_hold_q  <= HOLD_ON_RESET;
            busy_q      <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            ncs_sync_q  <= ncs_sync_d;
            sck_sync_q  <= sck_sync_d;
            mosi_sync_q <= mosi_sync_d;
            ncs_prev_q  <= ncs_prev_d;
            sck_prev_q  <= sck_prev_d;
            shift_q     <= shift_d;
            bit_cnt_q   <= bit_cnt_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_hold_q  <= cpu_hold_d;
            busy_q      <= busy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_hold  = cpu_hold_q;
    assign busy      = busy_q;
    assign frame_err = frame_err_q;

endmodule
